alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-issue controller that hands one instruction at a
// time to an external ALU unit bank and offers its result for writeback.
// Optional feature macro: ALU_TIMEOUT_EN. When it is defined, a
// multi-cycle operation that never signals unit_done is abandoned after
// TIMEOUT WAIT cycles and written back as an error.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both 1. The offering side holds valid and its payload stable until
// that edge. Here in_valid/in_ready accept instructions, and
// wb_valid/wb_ready hand results to the register file.
module alu_issue_ctrl #(
  parameter int N        = 16,
  parameter int SEL_LINE = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SEL_LINE-1:0] opcode,
  input  logic [N-1:0]        rs1_reg_val,
  input  logic [N-1:0]        rs2_reg_val,
  input  logic [3:0]          rd,
  output logic [6:0]          unit_sel,
  output logic                unit_start,
  output logic [N-1:0]        op_a,
  output logic [N-1:0]        op_b,
  input  logic                unit_done,
  input  logic [N-1:0]        unit_result,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [3:0]          wb_rd,
  output logic [N-1:0]        wb_data,
  output logic                wb_err,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SEL_LINE-1:0] r_opcode;
  logic [N-1:0]        r_op_a;
  logic [N-1:0]        r_op_b;
  logic [3:0]          r_rd;
  logic [N-1:0]        r_wb_data;
  logic                r_wb_err;

  logic                w_illegal;
  logic                w_multi;
  logic                w_div_zero;
  logic [6:0]          w_sel;
  logic                w_accept;
  logic                w_cap;
  logic [N-1:0]        w_cap_data;
  logic                w_cap_err;

  // Decode of the latched opcode; everything after accept uses the copy.
  always_comb begin
    w_illegal  = (r_opcode > SEL_LINE'(6));
    w_multi    = (r_opcode == SEL_LINE'(2)) || (r_opcode == SEL_LINE'(3));
    w_div_zero = (r_opcode == SEL_LINE'(3)) && (r_op_b == '0);
    w_sel      = '0;
    if (!w_illegal) begin
      w_sel[r_opcode[2:0]] = 1'b1;
    end
  end

  assign w_accept    = in_valid && in_ready;
  assign op_a        = r_op_a;
  assign op_b        = r_op_b;
  assign wb_rd       = r_rd;
  assign wb_data     = r_wb_data;
  assign wb_err      = r_wb_err;
  assign o_dbg_state = r_state;

`ifdef ALU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_to_cnt;
  logic          w_to_hit;

  assign w_to_hit = (r_to_cnt == CW'(TIMEOUT - 1));

  // Timeout counter: cleared on the way into WAIT, counts each WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (r_state == EXEC) begin
      r_to_cnt <= '0;
    end else if (r_state == WAIT) begin
      r_to_cnt <= r_to_cnt + CW'(1);
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, unit/handshake outputs and result capture strobes.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    unit_start  = 1'b0;
    unit_sel    = '0;
    wb_valid    = 1'b0;
    w_cap       = 1'b0;
    w_cap_data  = '0;
    w_cap_err   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (w_illegal) begin
          // No unit is touched; result is zero with the error flag.
          w_cap       = 1'b1;
          w_cap_err   = 1'b1;
          w_state_nxt = WB;
        end else if (w_div_zero) begin
          // Divide by zero never reaches the divider.
          w_cap       = 1'b1;
          w_cap_data  = '1;
          w_cap_err   = 1'b1;
          w_state_nxt = WB;
        end else begin
          unit_start = 1'b1;
          unit_sel   = w_sel;
          if (w_multi) begin
            w_state_nxt = WAIT;
          end else begin
            w_cap       = 1'b1;
            w_cap_data  = unit_result;
            w_state_nxt = WB;
          end
        end
      end
      WAIT: begin
        unit_sel = w_sel;
        if (unit_done) begin
          w_cap       = 1'b1;
          w_cap_data  = unit_result;
          w_state_nxt = WB;
        end
`ifdef ALU_TIMEOUT_EN
        else if (w_to_hit) begin
          w_cap       = 1'b1;
          w_cap_err   = 1'b1;
          w_state_nxt = WB;
        end
`endif
      end
      WB: begin
        wb_valid = 1'b1;
        if (wb_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Instruction latch on accept; operands stay on op_a/op_b until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opcode <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_rd     <= '0;
    end else if (w_accept) begin
      r_opcode <= opcode;
      r_op_a   <= rs1_reg_val;
      r_op_b   <= rs2_reg_val;
      r_rd     <= rd;
    end
  end

  // Writeback payload, captured once per instruction and held through WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_data <= '0;
      r_wb_err  <= 1'b0;
    end else if (w_cap) begin
      r_wb_data <= w_cap_data;
      r_wb_err  <= w_cap_err;
    end
  end

endmodule
